// File: rtl/mmio_pkg.sv
// Shared definitions for the memory-mapped UART controller.
// Holds the register offsets relative to the IO window base, the STATUS
// register bit positions and the canonical NOP encoding (addi x0,x0,0).
package mmio_pkg;

    localparam logic [31:0] OFF_STATUS     = 32'h00;
    localparam logic [31:0] OFF_RX_DATA    = 32'h04;
    localparam logic [31:0] OFF_TX_DATA    = 32'h08;
    localparam logic [31:0] OFF_LEVELS     = 32'h0C;
    localparam logic [31:0] OFF_CYCLE      = 32'h10;
    localparam logic [31:0] OFF_INSTR      = 32'h14;
    localparam logic [31:0] OFF_CNT_CLR    = 32'h18;
    localparam logic [31:0] OFF_STATUS_CLR = 32'h1C;

    localparam int unsigned ST_TX_NOT_FULL  = 0;
    localparam int unsigned ST_RX_NOT_EMPTY = 1;
    localparam int unsigned ST_TX_EMPTY     = 2;
    localparam int unsigned ST_TX_DROP      = 3;

    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with fall-through head.
// Ports:
//   clk, rst       - clock, synchronous active-high reset (pointers/count only)
//   push, din      - write request and data; ignored while full
//   pop            - read request; ignored while empty
//   dout           - current head entry (valid while !empty)
//   full, empty    - occupancy flags
//   count          - number of stored entries, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // A push while full is dropped even if a pop happens in the same cycle.
    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage is data only; stale entries are unreachable once pointers reset.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/mmio_uart_ctrl.sv
// Memory-mapped IO controller between the CPU data path and the UART core.
// Ports:
//   clk, rst              - CPU clock, synchronous active-high reset
//   addr, wdata           - CPU byte address (word aligned) and store data
//   rd_en, wr_en          - load / store strobes for this cycle
//   inst_valid, inst_is_nop - retirement info for the instruction counter
//   rdata                 - registered load data (one-cycle latency)
//   rx_data/valid/ready   - receiver byte stream into the RX FIFO
//   tx_data/valid/ready   - transmitter byte stream out of the TX FIFO
// Registers: STATUS, RX_DATA, TX_DATA, LEVELS, CYCLE, INSTR, CNT_CLR,
// STATUS_CLR at BASE_ADDR + 0x00..0x1C; other addresses read as zero.
module mmio_uart_ctrl import mmio_pkg::*; #(
    parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
    parameter int          FIFO_DEPTH = 8,
    parameter int          CNT_W      = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        rd_en,
    input  logic        wr_en,
    input  logic        inst_valid,
    input  logic        inst_is_nop,
    output logic [31:0] rdata,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);

    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    logic [31:0]      off;
    logic             rd_rx;
    logic             wr_tx;
    logic             wr_cnt_clr;
    logic             wr_st_clr;
    logic [7:0]       rx_dout;
    logic             rx_full;
    logic             rx_empty;
    logic [LW-1:0]    rx_count;
    logic             tx_full;
    logic             tx_empty;
    logic [LW-1:0]    tx_count;
    logic             tx_drop;
    logic [CNT_W-1:0] cycle_cnt;
    logic [CNT_W-1:0] cycle_nxt;
    logic [CNT_W-1:0] instr_cnt;
    logic [CNT_W-1:0] instr_nxt;
    logic [31:0]      status;
    logic [31:0]      rd_mux;
    logic             unused_wdata;

    // Offset from the window base; an exact offset match is a register hit.
    assign off        = addr - BASE_ADDR;
    assign rd_rx      = rd_en && (off == OFF_RX_DATA);
    assign wr_tx      = wr_en && (off == OFF_TX_DATA);
    assign wr_cnt_clr = wr_en && (off == OFF_CNT_CLR);
    assign wr_st_clr  = wr_en && (off == OFF_STATUS_CLR);
    assign unused_wdata = ^wdata[31:8];

    assign rx_ready = !rx_full;
    assign tx_valid = !tx_empty;

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) RX_FIFO (
        .clk   (clk),
        .rst   (rst),
        .push  (rx_valid && rx_ready),
        .din   (rx_data),
        .pop   (rd_rx),
        .dout  (rx_dout),
        .full  (rx_full),
        .empty (rx_empty),
        .count (rx_count)
    );

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) TX_FIFO (
        .clk   (clk),
        .rst   (rst),
        .push  (wr_tx),
        .din   (wdata[7:0]),
        .pop   (tx_valid && tx_ready),
        .dout  (tx_data),
        .full  (tx_full),
        .empty (tx_empty),
        .count (tx_count)
    );

    // A store to a full TX FIFO marks the loss; the loss wins over a clear.
    always_ff @(posedge clk) begin
        if (rst)                                   tx_drop <= 1'b0;
        else if (wr_tx && tx_full)                 tx_drop <= 1'b1;
        else if (wr_st_clr && wdata[ST_TX_DROP])   tx_drop <= 1'b0;
    end

    // CNT_CLR has priority over both the free-running and retire increments.
    assign cycle_nxt = wr_cnt_clr ? '0 : cycle_cnt + 1'b1;
    assign instr_nxt = wr_cnt_clr ? '0 :
                       (inst_valid && !inst_is_nop) ? instr_cnt + 1'b1 : instr_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_cnt <= '0;
            instr_cnt <= '0;
        end else begin
            cycle_cnt <= cycle_nxt;
            instr_cnt <= instr_nxt;
        end
    end

    always_comb begin
        status                  = '0;
        status[ST_TX_NOT_FULL]  = !tx_full;
        status[ST_RX_NOT_EMPTY] = !rx_empty;
        status[ST_TX_EMPTY]     = tx_empty;
        status[ST_TX_DROP]      = tx_drop;
    end

    // Counter reads return the value the counter takes at this edge, so a
    // load one cycle after a clear observes 1.
    always_comb begin
        rd_mux = '0;
        case (off)
            OFF_STATUS:  rd_mux = status;
            OFF_RX_DATA: rd_mux = rx_empty ? 32'h0 : {24'h0, rx_dout};
            OFF_LEVELS:  rd_mux = {16'h0, 8'(tx_count), 8'(rx_count)};
            OFF_CYCLE:   rd_mux = 32'(cycle_nxt);
            OFF_INSTR:   rd_mux = 32'(instr_nxt);
            default:     rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)        rdata <= '0;
        else if (rd_en) rdata <= rd_mux;
    end

endmodule
